// File: rtl/jtkicker_dwnld_pkg.sv
// Shared types and helpers for the kicker-family ROM download router.
package jtkicker_dwnld_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SD_WR   = 2'd1,
      PROM_WR = 2'd2
   } state_t;

   // One downloaded byte with its ioctl byte address
   typedef struct packed {
      logic [24:0] addr;
      logic [7:0]  data;
   } byte_rec_t;

   function automatic logic [7:0] nibswap(input logic [7:0] d);
      return {d[3:0], d[7:4]};
   endfunction

endpackage

// File: rtl/jtkicker_dwnld_rgn.sv
// NSWAP-way address-region comparator. Regions are [lo, hi) on the low 22 address
// bits; the hit output is an OR, so overlapping regions still yield a single swap.
module jtkicker_dwnld_rgn
   import jtkicker_dwnld_pkg::*;
#(
   parameter int unsigned             NSWAP   = 2,
   parameter logic [NSWAP*22-1:0]     SWAP_LO = (NSWAP*22)'(22'h4000),
   parameter logic [NSWAP*22-1:0]     SWAP_HI = (NSWAP*22)'(22'h8000)
)(
   input  logic [21:0] addr,
   output logic        hit
);

   // OR of all region hits
   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < NSWAP; i++) begin
         if (addr >= SWAP_LO[i*22 +: 22] && addr < SWAP_HI[i*22 +: 22]) hit = 1'b1;
      end
   end

endmodule

// File: rtl/jtkicker_dwnld_router.sv
// ROM download router: ioctl byte stream -> SDRAM loader / PROM write strobes.
// Bytes are nibble-swapped at acceptance, so the one-deep pending buffer already
// holds transformed data. Optional running checksum enabled by JTKICKER_CKSUM_EN.
module jtkicker_dwnld_router
   import jtkicker_dwnld_pkg::*;
#(
   parameter int unsigned         NSWAP      = 2,
   parameter logic [NSWAP*22-1:0] SWAP_LO    = (NSWAP*22)'(22'h4000),
   parameter logic [NSWAP*22-1:0] SWAP_HI    = (NSWAP*22)'(22'h8000),
   parameter logic [24:0]         PROM_START = 25'h1_0000,
   parameter int unsigned         PROMW      = 11,
   parameter bit                  SWAB       = 1'b1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             downloading,
   input  logic [24:0]      ioctl_addr,
   input  logic [7:0]       ioctl_dout,
   input  logic             ioctl_wr,
   input  logic             sdram_ack,
   output logic [21:0]      prog_addr,
   output logic [15:0]      prog_data,
   output logic [1:0]       prog_mask,
   output logic             prog_we,
   output logic             prom_we,
   output logic [PROMW-1:0] prom_addr,
   output logic             dwnld_busy,
   output logic             ovf
`ifdef JTKICKER_CKSUM_EN
   ,
   output logic [15:0]      checksum
`endif
);

   state_t    state;
   byte_rec_t pend;
   logic      pend_valid;
   logic      dl_q;
   logic      swap_hit;
   logic      dl_rise;
   logic      take;
   logic      drop;
   logic      upper;
   byte_rec_t in_rec;
   byte_rec_t cur;

   jtkicker_dwnld_rgn #(
      .NSWAP   (NSWAP),
      .SWAP_LO (SWAP_LO),
      .SWAP_HI (SWAP_HI)
   ) u_rgn (
      .addr (ioctl_addr[21:0]),
      .hit  (swap_hit)
   );

   // Incoming byte transform, launch selection and acceptance decisions
   always_comb begin
      in_rec.addr = ioctl_addr;
      in_rec.data = swap_hit ? nibswap(ioctl_dout) : ioctl_dout;
      // a waiting byte is older than the one arriving now, so it goes first
      cur         = pend_valid ? pend : in_rec;
      take        = (state == IDLE) && (ioctl_wr || pend_valid);
      drop        = ioctl_wr && (state != IDLE) && pend_valid;
      dl_rise     = downloading && !dl_q;
      // SWAB=1 places even bytes on the upper lane
      upper       = cur.addr[0] ^ SWAB;
   end

   assign dwnld_busy = downloading | (state != IDLE) | pend_valid;

   // Write FSM with registered SDRAM/PROM outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prog_we   <= 1'b0;
         prom_we   <= 1'b0;
         prog_addr <= '0;
         prog_data <= '0;
         prog_mask <= '0;
         prom_addr <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  prog_addr <= cur.addr[22:1];
                  prog_data <= {cur.data, cur.data};
                  prog_mask <= upper ? 2'b01 : 2'b10;
                  prom_addr <= PROMW'(cur.addr - PROM_START);
                  if (cur.addr >= PROM_START) begin
                     state   <= PROM_WR;
                     prom_we <= 1'b1;
                  end else begin
                     state   <= SD_WR;
                     prog_we <= 1'b1;
                  end
               end
            end
            SD_WR: begin
               if (sdram_ack) begin
                  prog_we <= 1'b0;
                  state   <= IDLE;
               end
            end
            PROM_WR: begin
               prom_we <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state   <= IDLE;
               prog_we <= 1'b0;
               prom_we <= 1'b0;
            end
         endcase
      end
   end

   // One-deep pending buffer, sticky overflow and download-rise tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend       <= '0;
         ovf        <= 1'b0;
         dl_q       <= 1'b0;
      end else begin
         dl_q <= downloading;
         if (state == IDLE) begin
            // pending drains this edge; a simultaneous new byte takes its place
            if (pend_valid) begin
               pend_valid <= ioctl_wr;
               if (ioctl_wr) pend <= in_rec;
            end
         end else if (ioctl_wr && !pend_valid) begin
            pend_valid <= 1'b1;
            pend       <= in_rec;
         end
         // a drop on the rising edge itself still counts as an overflow
         if (drop) ovf <= 1'b1;
         else if (dl_rise) ovf <= 1'b0;
      end
   end

`ifdef JTKICKER_CKSUM_EN
   logic accept;
   assign accept = ioctl_wr && !drop;

   // Running sum of every accepted (transformed) byte
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum <= '0;
      end else begin
         checksum <= (dl_rise ? 16'd0 : checksum) + (accept ? {8'd0, in_rec.data} : 16'd0);
      end
   end
`endif

endmodule

// File: tb/tb_jtkicker_dwnld_router.sv
// Self-checking bench for jtkicker_dwnld_router: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level queue model.
module tb_jtkicker_dwnld_router;

   localparam logic [24:0] PROM_START = 25'h1_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        downloading = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        ioctl_wr = 1'b0;
   logic        sdram_ack = 1'b0;
   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask;
   logic        prog_we;
   logic        prom_we;
   logic [10:0] prom_addr;
   logic        dwnld_busy;
   logic        ovf;
`ifdef JTKICKER_CKSUM_EN
   logic [15:0] checksum;
`endif

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   jtkicker_dwnld_router #(
      .NSWAP      (3),
      .SWAP_LO    ({22'h80, 22'h0, 22'h4000}),
      .SWAP_HI    ({22'h200, 22'h100, 22'h8000}),
      .PROM_START (PROM_START),
      .PROMW      (11),
      .SWAB       (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .ioctl_addr  (ioctl_addr),
      .ioctl_dout  (ioctl_dout),
      .ioctl_wr    (ioctl_wr),
      .sdram_ack   (sdram_ack),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_mask   (prog_mask),
      .prog_we     (prog_we),
      .prom_we     (prom_we),
      .prom_addr   (prom_addr),
      .dwnld_busy  (dwnld_busy),
      .ovf         (ovf)
`ifdef JTKICKER_CKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [24:0] addr;
      logic [7:0]  data;
   } rec_t;

   logic [21:0] rlo [3] = '{22'h4000, 22'h0, 22'h80};
   logic [21:0] rhi [3] = '{22'h8000, 22'h100, 22'h200};

   rec_t        q[$];        // accepted bytes not yet launched
   int          mode = 0;    // 0 none, 1 SDRAM write open, 2 PROM strobe
   bit          m_valid = 0;
   bit          m_dlq = 0;
   bit          m_ovf = 0;
   logic [21:0] m_pa = '0;
   logic [15:0] m_pd = '0;
   logic [1:0]  m_pm = '0;
   logic [10:0] m_pra = '0;
   logic [15:0] m_ck = '0;

   function automatic bit in_swap(input logic [24:0] a);
      for (int i = 0; i < 3; i++) if (a[21:0] >= rlo[i] && a[21:0] < rhi[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         mode = 0; m_dlq = 0; m_ovf = 0; m_ck = '0;
         m_pa = '0; m_pd = '0; m_pm = '0; m_pra = '0;
         m_valid = 1;
      end else begin
         bit   idle, acc, rise;
         rec_t r;
         idle = (mode == 0);
         rise = downloading && !m_dlq;
         // room exists when nothing is in flight or nothing is waiting
         acc  = ioctl_wr && (idle || q.size() == 0);
         m_ovf = (ioctl_wr && !acc) ? 1'b1 : (rise ? 1'b0 : m_ovf);
         r.addr = ioctl_addr;
         r.data = in_swap(ioctl_addr) ? {ioctl_dout[3:0], ioctl_dout[7:4]} : ioctl_dout;
         m_ck = (rise ? 16'd0 : m_ck) + (acc ? {8'd0, r.data} : 16'd0);
         if (acc) q.push_back(r);
         if (idle) begin
            if (q.size() > 0) begin
               r     = q.pop_front();
               mode  = (r.addr >= PROM_START) ? 2 : 1;
               m_pa  = r.addr[22:1];
               m_pd  = {r.data, r.data};
               m_pm  = (r.addr[0] == 1'b0) ? 2'b01 : 2'b10;
               m_pra = 11'((r.addr - PROM_START) & 25'h7FF);
            end
         end else if (mode == 2 || sdram_ack) begin
            mode = 0;
         end
         m_dlq = downloading;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid) begin
         chk("prog_we", {31'd0, prog_we}, {31'd0, mode == 1});
         chk("prom_we", {31'd0, prom_we}, {31'd0, mode == 2});
         chk("prog_addr", {10'd0, prog_addr}, {10'd0, m_pa});
         chk("prog_data", {16'd0, prog_data}, {16'd0, m_pd});
         chk("prog_mask", {30'd0, prog_mask}, {30'd0, m_pm});
         chk("prom_addr", {21'd0, prom_addr}, {21'd0, m_pra});
         chk("dwnld_busy", {31'd0, dwnld_busy},
             {31'd0, downloading | (mode != 0) | (q.size() != 0)});
         chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`ifdef JTKICKER_CKSUM_EN
         chk("checksum", {16'd0, checksum}, {16'd0, m_ck});
`endif
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_prog_we", {31'd0, prog_we}, 32'd0);
      chk("rst_prom_we", {31'd0, prom_we}, 32'd0);
      chk("rst_busy", {31'd0, dwnld_busy}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_prog_data", {16'd0, prog_data}, 32'd0);
      downloading = 1'b1;
      step();

      // 1: swapped SDRAM byte, ack sampled on the third edge
      ioctl_addr = 25'h4001; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
      step();
      ioctl_wr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) sdram_ack = 1'b1;
         @(negedge clk);
         chk("t1_prog_we_high", {31'd0, prog_we}, 32'd1);
         if (k == 0) begin
            chk("t1_prog_data", {16'd0, prog_data}, 32'h5A5A);
            chk("t1_prog_addr", {10'd0, prog_addr}, 32'h2000);
            chk("t1_prog_mask", {30'd0, prog_mask}, 32'h2);
         end
         step();
      end
      sdram_ack = 1'b0;
      @(negedge clk);
      chk("t1_prog_we_low", {31'd0, prog_we}, 32'd0);

      // 2: PROM byte
      ioctl_addr = 25'h1_0003; ioctl_dout = 8'h0F; ioctl_wr = 1'b1;
      step();
      ioctl_wr = 1'b0;
      @(negedge clk);
      chk("t2_prom_we", {31'd0, prom_we}, 32'd1);
      chk("t2_prom_addr", {21'd0, prom_addr}, 32'd3);
      chk("t2_prog_we", {31'd0, prog_we}, 32'd0);
      step();
      @(negedge clk);
      chk("t2_prom_we_low", {31'd0, prom_we}, 32'd0);
      chk("t2_prog_we_low", {31'd0, prog_we}, 32'd0);

      // 3: back-to-back bytes, ack withheld
      for (int k = 0; k < 3; k++) begin
         ioctl_addr = 25'h300 + 25'(2 * k); ioctl_dout = 8'h11 * 8'(k + 1); ioctl_wr = 1'b1;
         step();
      end
      ioctl_wr = 1'b0;
      @(negedge clk);
      chk("t3_ovf", {31'd0, ovf}, 32'd1);
      chk("t3_first_addr", {10'd0, prog_addr}, 32'h180);
      repeat (2) step();
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      @(negedge clk);
      chk("t3_gap_we", {31'd0, prog_we}, 32'd0);
      chk("t3_gap_busy", {31'd0, dwnld_busy}, 32'd1);
      step();
      @(negedge clk);
      chk("t3_second_we", {31'd0, prog_we}, 32'd1);
      chk("t3_second_addr", {10'd0, prog_addr}, 32'h181);
      chk("t3_second_data", {16'd0, prog_data}, 32'h2222);
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      downloading = 1'b0;
      step();
      @(negedge clk);
      chk("t3_ovf_after_fall", {31'd0, ovf}, 32'd1);
      downloading = 1'b1;
      step();
      @(negedge clk);
      chk("t3_ovf_cleared", {31'd0, ovf}, 32'd0);

      // 4: reset mid SDRAM write with a byte pending
      ioctl_addr = 25'h10; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
      step();
      ioctl_addr = 25'h12;
      step();
      ioctl_wr = 1'b0;
      rst = 1'b1; downloading = 1'b0;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t4_prog_we", {31'd0, prog_we}, 32'd0);
      chk("t4_busy", {31'd0, dwnld_busy}, 32'd0);
      downloading = 1'b1;
      step();

      // 5: overlapping regions swap once
      ioctl_addr = 25'h90; ioctl_dout = 8'h12; ioctl_wr = 1'b1;
      step();
      ioctl_wr = 1'b0;
      @(negedge clk);
      chk("t5_prog_data", {16'd0, prog_data}, 32'h2121);
      chk("t5_prog_mask", {30'd0, prog_mask}, 32'h1);
      chk("t5_prog_addr", {10'd0, prog_addr}, 32'h48);
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;

`ifdef JTKICKER_CKSUM_EN
      // 6: checksum over two unswapped bytes, cleared by a new download
      downloading = 1'b0; step();
      downloading = 1'b1; step();
      @(negedge clk);
      chk("t6_cks_zero", {16'd0, checksum}, 32'd0);
      ioctl_addr = 25'h300; ioctl_dout = 8'hFF; ioctl_wr = 1'b1;
      step();
      ioctl_addr = 25'h301; ioctl_dout = 8'h02;
      step();
      ioctl_wr = 1'b0;
      @(negedge clk);
      chk("t6_cks_sum", {16'd0, checksum}, 32'h0101);
      sdram_ack = 1'b1;
      repeat (3) step();
      sdram_ack = 1'b0;
      downloading = 1'b0; step();
      downloading = 1'b1; step();
      @(negedge clk);
      chk("t6_cks_cleared", {16'd0, checksum}, 32'd0);
`endif

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         ioctl_wr = ($urandom_range(0, 99) < 40);
         case ($urandom_range(0, 3))
            0: ioctl_addr = 25'($urandom_range(0, 'h2ff));
            1: ioctl_addr = 25'($urandom_range('h3f00, 'h80ff));
            2: ioctl_addr = PROM_START + 25'($urandom_range(0, 'h900));
            default: ioctl_addr = 25'($urandom);
         endcase
         ioctl_dout = 8'($urandom);
         sdram_ack  = ($urandom_range(0, 99) < 35);
         if ($urandom_range(0, 199) == 0) downloading = ~downloading;
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0; ioctl_wr = 1'b0; sdram_ack = 1'b1;
      repeat (5) step();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
